boot_seq: RTL and testbench

Boot sequencer for the processor core: accepts a program as a valid/ready word stream, writes it into instruction memory through the core's load port (address / write enable / write data), then raises `working` for a bounded or halt-terminated run. It sits between the host/test harness and the processor top, replacing hand-driven memory-load and start sequences.

---
 rtl/boot_seq_if.sv | 19 +
 rtl/boot_seq.sv | 164 ++++++++++++++++
 tb/tb_boot_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_seq_if.sv
// Program word stream from the host into the boot sequencer.
// The host drives valid/data; the sequencer returns ready.
interface boot_seq_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/boot_seq.sv
// Boot sequencer: streams a program into instruction memory through the
// core's load port, then enables the core for a bounded or halted run.
module boot_seq #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  len,
    input  logic [15:0] run_len,
    boot_seq_if.slave   s_in,
    input  logic        halt,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        working,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [8:0] LEN_MAX = 9'(DEPTH);

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_len;
    logic [15:0] r_run_len;
    logic [7:0]  r_wc;
    logic [15:0] r_rc;
    logic        r_in_ready;
    logic [31:0] r_mem_addr;
    logic        r_mem_wr;
    logic [31:0] r_mem_wdata;
    logic        r_working;
    logic        r_done;
    logic        r_err;

    logic [7:0]  w_wc;
    logic [15:0] w_rc;
    logic        w_in_ready;
    logic [31:0] w_mem_addr;
    logic        w_mem_wr;
    logic [31:0] w_mem_wdata;
    logic        w_working;
    logic        w_done;
    logic        w_err;

    logic        w_len_ok;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    logic        w_run_end;

    assign w_len_ok  = (len != 8'd0) && ({1'b0, len} <= LEN_MAX);
    assign w_accept  = (r_state == S_IDLE) && start && w_len_ok;
    assign w_xfer    = (r_state == S_LOAD) && s_in.in_valid && r_in_ready;
    assign w_last    = w_xfer && (r_wc == (r_len - 8'd1));
    assign w_run_end = halt
                     || ((r_run_len != 16'd0)
                         && (r_rc == (r_run_len - 16'd1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= 8'd0;
            r_run_len   <= 16'd0;
            r_wc        <= 8'd0;
            r_rc        <= 16'd0;
            r_in_ready  <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_working   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wc        <= w_wc;
            r_rc        <= w_rc;
            r_in_ready  <= w_in_ready;
            r_mem_addr  <= w_mem_addr;
            r_mem_wr    <= w_mem_wr;
            r_mem_wdata <= w_mem_wdata;
            r_working   <= w_working;
            r_done      <= w_done;
            r_err       <= w_err;
            if (w_accept) begin
                r_len     <= len;
                r_run_len <= run_len;
            end
        end
    end

    // abort outranks every other transition, including halt and the last word
    always_comb begin
        w_next = r_state;
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (w_accept) w_next = S_LOAD;
                S_LOAD:   if (w_last) w_next = S_FLUSH;
                S_FLUSH:  w_next = S_SETTLE;
                S_SETTLE: w_next = S_RUN;
                S_RUN:    if (w_run_end) w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        w_in_ready  = (w_next == S_LOAD);
        w_working   = (w_next == S_RUN);
        w_done      = (w_next == S_DONE);
        w_mem_wr    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_wc        = r_wc;
        w_rc        = r_rc;
        w_err       = r_err;
        if ((r_state == S_IDLE) && start) begin
            w_err = !w_len_ok;
            w_wc  = 8'd0;
        end
        if (w_xfer && !abort) begin
            w_mem_wr    = 1'b1;
            w_mem_addr  = {24'd0, r_wc};
            w_mem_wdata = s_in.in_data;
            w_wc        = r_wc + 8'd1;
        end
        if ((r_state == S_FLUSH) && !abort) begin
            w_mem_addr  = 32'd0;
            w_mem_wdata = 32'd0;
        end
        if (r_state == S_SETTLE) begin
            w_rc = 16'd0;
        end else if (r_state == S_RUN) begin
            w_rc = r_rc + 16'd1;
        end
    end

    assign s_in.in_ready = r_in_ready;
    assign mem_addr      = r_mem_addr;
    assign mem_wr        = r_mem_wr;
    assign mem_wdata     = r_mem_wdata;
    assign working       = r_working;
    assign done          = r_done;
    assign err           = r_err;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_boot_seq.sv
// Randomized scoreboard bench for boot_seq: expected writes and run
// outcomes are queued by the driver and popped by an output monitor.
module tb_boot_seq;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        halt  = 1'b0;
    logic [7:0]  len = 8'd0;
    logic [15:0] run_len = 16'd0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        working;
    logic        busy;
    logic        done;
    logic        err;

    boot_seq_if s_in ();

    boot_seq #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .len      (len),
        .run_len  (run_len),
        .s_in     (s_in),
        .halt     (halt),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .working  (working),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int n;
        bit dn;
    } run_t;

    wr_t         wq[$];
    run_t        rq[$];
    logic [31:0] prog [DEPTH];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk(mem_addr == 0, {tag, " mem_addr"}, mem_addr, 0);
        chk(mem_wdata == 0, {tag, " mem_wdata"}, mem_wdata, 0);
        chk(mem_wr == 0, {tag, " mem_wr"}, mem_wr, 0);
        chk(working == 0, {tag, " working"}, working, 0);
        chk(s_in.in_ready == 0, {tag, " in_ready"}, s_in.in_ready, 0);
        chk(busy == 0, {tag, " busy"}, busy, 0);
        chk(done == 0, {tag, " done"}, done, 0);
        chk(err == 0, {tag, " err"}, err, 0);
    endtask

    // Output monitor: write order, run length, done pulse, run entry timing.
    int          cyc = 0;
    int          last_wr = -100;
    int          wcnt = 0;
    bit          p_work = 0;
    bit          p_wr = 0;
    logic [31:0] p_addr = 0;
    logic [31:0] p_data = 0;
    wr_t         ew;
    run_t        er;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (mem_wr) begin
                if (wq.size() == 0) begin
                    chk(0, "unexpected write", mem_addr, 0);
                end else begin
                    ew = wq.pop_front();
                    chk(mem_addr == ew.a, "wr_addr", mem_addr, ew.a);
                    chk(mem_wdata == ew.d, "wr_data", mem_wdata, ew.d);
                end
                last_wr = cyc;
            end
            if (working && !p_work) begin
                chk(cyc - last_wr == 2, "run_entry_gap", cyc - last_wr, 2);
                chk(!p_wr && p_addr == 0 && p_data == 0,
                    "settle_port", p_addr, 0);
                wcnt = 0;
            end
            if (working) wcnt++;
            if (p_work && !working) begin
                if (rq.size() == 0) begin
                    chk(0, "unexpected run end", wcnt, 0);
                end else begin
                    er = rq.pop_front();
                    chk(wcnt == er.n, "run_cycles", wcnt, er.n);
                    chk(done == er.dn, "done_at_end", done, er.dn);
                end
            end else if (done) begin
                chk(0, "stray done", done, 0);
            end
            p_work = working;
            p_wr   = mem_wr;
            p_addr = mem_addr;
            p_data = mem_wdata;
        end
    end

    task automatic do_start(input logic [7:0] l, input logic [15:0] rl);
        @(negedge clock);
        len = l;
        run_len = rl;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic load_words(input int n, input int stall,
                              input int abort_after, output bit ab);
        int i = 0;
        int g = 0;
        bit v;
        ab = 0;
        while (i < n && g < 200) begin
            if (abort_after == i) begin
                s_in.in_valid = 1'b1;
                s_in.in_data  = prog[i];
                abort = 1'b1;
                @(negedge clock);
                abort = 1'b0;
                s_in.in_valid = 1'b0;
                chk(busy == 0, "abort_load busy", busy, 0);
                chk(s_in.in_ready == 0, "abort_load ready", s_in.in_ready, 0);
                chk(working == 0, "abort_load working", working, 0);
                ab = 1;
                return;
            end
            if (stall == 0) v = 1;
            else if (stall == 1) v = (g % 2 == 0);
            else v = ($urandom_range(0, 3) != 0);
            s_in.in_valid = v;
            s_in.in_data  = v ? prog[i] : $urandom;
            if (stall == 2) begin
                start = ($urandom_range(0, 7) == 0);
                len   = 8'($urandom);
                halt  = ($urandom_range(0, 5) == 0);
            end
            if (v && s_in.in_ready) begin
                wq.push_back('{32'(i), prog[i]});
                i++;
            end
            @(negedge clock);
            g++;
        end
        s_in.in_valid = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        if (i < n) chk(0, "load timeout", i, n);
    endtask

    task automatic run_phase(input logic [15:0] rl, input int halt_at,
                             input int abort_at, input int reset_at);
        int g = 0;
        int cnt = 1;
        while (!working && g < 8) begin
            @(negedge clock);
            g++;
        end
        if (!working) begin
            chk(0, "run start timeout", g, 2);
            return;
        end
        while (1) begin
            if (halt_at == cnt) begin
                halt = 1'b1;
                rq.push_back('{cnt, 1'b1});
                @(negedge clock);
                halt = 1'b0;
                break;
            end
            if (abort_at == cnt) begin
                abort = 1'b1;
                halt  = 1'b1;
                rq.push_back('{cnt, 1'b0});
                @(negedge clock);
                abort = 1'b0;
                halt  = 1'b0;
                chk(busy == 0, "abort_run busy", busy, 0);
                break;
            end
            if (reset_at == cnt) begin
                #2 reset = 1'b1;
                #1 check_zero("reset_run");
                rq.push_back('{cnt, 1'b0});
                @(negedge clock);
                reset = 1'b0;
                break;
            end
            if (rl != 0 && cnt == int'(rl)) begin
                rq.push_back('{cnt, 1'b1});
                break;
            end
            if (cnt >= 400) begin
                chk(0, "run timeout", cnt, 0);
                break;
            end
            @(negedge clock);
            cnt++;
            if (!working) begin
                chk(0, "working dropped early", cnt, 0);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 10) begin
            @(negedge clock);
            g++;
        end
        chk(busy == 0, "return to idle", busy, 0);
        @(negedge clock);
    endtask

    task automatic prog_run(input int n, input logic [15:0] rl,
                            input int stall, input int halt_at,
                            input int abort_load, input int abort_run,
                            input int reset_run);
        bit ab;
        do_start(8'(n), rl);
        chk(busy == 1 && err == 0, "start accepted", {busy, err}, 2);
        load_words(n, stall, abort_load, ab);
        if (!ab) run_phase(rl, halt_at, abort_run, reset_run);
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int h;
        logic [15:0] rl;
        s_in.in_valid = 1'b0;
        s_in.in_data  = 32'd0;
        prog[0] = 32'h10f00010;
        prog[1] = 32'h20010000;
        prog[2] = 32'h21230000;
        prog[3] = 32'h22450000;
        prog[4] = 32'h23670000;
        for (int i = 5; i < DEPTH; i++) prog[i] = $urandom;
        #2 reset = 1'b1;
        #3 check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        prog_run(5, 16'd7, 0, 0, -1, 0, 0);
        prog_run(5, 16'd7, 1, 0, -1, 0, 0);
        prog_run(5, 16'd0, 0, 12, -1, 0, 0);

        do_start(8'd0, 16'd5);
        chk(err == 1 && busy == 0, "len0 err", {err, busy}, 2);
        do_start(8'(DEPTH + 1), 16'd5);
        chk(err == 1 && busy == 0, "len17 err", {err, busy}, 2);
        repeat (3) @(negedge clock);
        chk(working == 0, "bad start working", working, 0);
        prog_run(3, 16'd4, 0, 0, -1, 0, 0);
        chk(err == 0, "err cleared", err, 0);

        prog_run(5, 16'd7, 0, 0, 2, 0, 0);
        prog_run(4, 16'd0, 0, 0, -1, 5, 0);
        prog_run(5, 16'd0, 0, 0, -1, 0, 6);
        prog_run(5, 16'd7, 0, 0, -1, 0, 0);

        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
            n  = $urandom_range(1, DEPTH);
            rl = 16'($urandom_range(0, 20));
            h  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : 0;
            if (rl == 0 && h == 0) h = $urandom_range(1, 25);
            prog_run(n, rl, $urandom_range(0, 2), h, -1, 0, 0);
        end

        repeat (4) @(negedge clock);
        chk(wq.size() == 0, "writes outstanding", wq.size(), 0);
        chk(rq.size() == 0, "runs outstanding", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
